// File: rtl/instr_encoder.sv
// Assembles 32-bit MIPS instruction words from field requests and writes them
// into instruction memory at consecutive word addresses starting at BASE_ADDR.
module instr_encoder #(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_ready,
  output logic [7:0]  word_count,
  output logic        full,
  output logic        error,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  state_t      state;
  logic [5:0]  opcode;
  logic        op_valid;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [31:0] word;
  logic        accept;
  logic [7:0]  next_count;

  assign dbg_state = state;

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready
  // (and clear is low); a memory write transfers where mem_wr_en && mem_ready.
  // The producer holds its payload stable while valid is high and ready is low.
  assign in_ready   = !full && (state == IDLE || mem_ready);
  assign accept     = in_valid && in_ready && !clear;
  assign next_count = word_count + 8'd1;

  always_comb begin
    opcode   = 6'b000000;
    op_valid = 1'b1;
    rs_f     = rs;
    rt_f     = rt;
    case (op_sel)
      5'd0:  opcode = 6'b000000;
      5'd1:  opcode = 6'b011100;
      5'd2:  opcode = 6'b011111;
      5'd3:  opcode = 6'b001000;
      5'd4:  opcode = 6'b001001;
      5'd5:  opcode = 6'b001100;
      5'd6:  opcode = 6'b001101;
      5'd7:  opcode = 6'b001110;
      5'd8:  opcode = 6'b001010;
      5'd9:  opcode = 6'b001011;
      5'd10: begin opcode = 6'b001111; rs_f = 5'd0; end
      5'd11: opcode = 6'b000100;
      5'd12: opcode = 6'b000101;
      5'd13: begin opcode = 6'b000111; rt_f = 5'd0; end
      5'd14: opcode = 6'b000001;
      5'd15: begin opcode = 6'b000110; rt_f = 5'd0; end
      5'd16: opcode = 6'b000010;
      5'd17: opcode = 6'b000011;
      5'd18: opcode = 6'b100011;
      5'd19: opcode = 6'b100000;
      5'd20: opcode = 6'b100001;
      5'd21: opcode = 6'b101011;
      5'd22: opcode = 6'b101000;
      5'd23: opcode = 6'b101001;
      default: op_valid = 1'b0;
    endcase
  end

  always_comb begin
    word = {opcode, rs_f, rt_f, imm};
    if (op_sel <= 5'd2)
      word = {opcode, rs, rt, rd, shamt, funct};
    else if (op_sel == 5'd16 || op_sel == 5'd17)
      word = {opcode, target};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= IDLE;
      mem_wr_en   <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wr_data <= 32'h0;
      word_count  <= 8'd0;
      full        <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (accept && op_valid) begin
        state       <= PEND;
        mem_wr_en   <= 1'b1;
        mem_addr    <= BASE_ADDR + {22'b0, word_count, 2'b00};
        mem_wr_data <= word;
        word_count  <= next_count;
        full        <= (next_count == DEPTH_W);
      end else if (state == PEND && mem_ready) begin
        state     <= IDLE;
        mem_wr_en <= 1'b0;
      end
      // An invalid select is consumed without a write but leaves a sticky flag.
      if (accept && !op_valid)
        error <= 1'b1;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction word generator for the MIPS datapath; the inverse of the opcode-to-control decode path. It accepts one operation request per handshake (operation select plus register, immediate and target fields) and assembles the 32-bit MIPS instruction word. It writes each word into instruction memory at an auto-incrementing address. Used by the calculator front end and test benches to load programs.

## Interface
- DEPTH, 128: instruction-memory capacity in words.
- BASE_ADDR, 32'h0: byte address of the first word written.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Clear  in  1  synchronous restart; same effect as Reset on all state.
- InValid  in  1  request present.
- InReady  out  1  request accepted when InValid && InReady at a rising edge.
- OpSel  in  5  operation select: 0 SPECIAL, 1 SPECIAL2, 2 SPECIAL3, 3 ADDI, 4 ADDIU, 5 ANDI, 6 ORI, 7 XORI, 8 SLTI, 9 SLTIU, 10 LUI, 11 BEQ, 12 BNE, 13 BGTZ, 14 REGIMM, 15 BLEZ, 16 J, 17 JAL, 18 LW, 19 LB, 20 LH, 21 SW, 22 SB, 23 SH; 24–31 invalid.
- Rs, Rt, Rd, Shamt  in  5 each  register and shift fields.
- Funct  in  6  function field.
- Imm  in  16  immediate/offset.
- Target  in  26  jump target field.
- MemWrEn  out  1  write request to instruction memory.
- MemAddr  out  32  byte address of the write.
- MemWrData  out  32  encoded instruction.
- MemReady  in  1  memory accepts the write when MemWrEn && MemReady at a rising edge.
- WordCount  out  8  words accepted since reset/clear.
- Full  out  1  WordCount == DEPTH.
- Error  out  1  sticky; an invalid OpSel was presented.

## Operation
- Opcodes by OpSel 0–23:
  - SPECIAL–SPECIAL3: 000000, 011100, 011111.
  - Immediate ALU ops: ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011, LUI 001111.
  - Branches: BEQ 000100, BNE 000101, BGTZ 000111, REGIMM 000001, BLEZ 000110.
  - Jumps: J 000010, JAL 000011.
  - Loads/stores: LW 100011, LB 100000, LH 100001, SW 101011, SB 101000, SH 101001.
- Formats:
  - R (0–2): {op, Rs, Rt, Rd, Shamt, Funct}.
  - I (3–15, 18–23): {op, Rs, Rt, Imm}.
    - LUI forces the rs field to 0.
    - BGTZ and BLEZ force the rt field to 0.
    - REGIMM passes Rt through (0 BLTZ, 1 BGEZ).
  - J (16–17): {op, Target}.
- States:
  - IDLE: no word pending.
  - PEND: MemWrEn=1, holding MemAddr/MemWrData stable until MemReady.
- InReady = !Full && (state==IDLE || MemReady).
- Accept with valid OpSel:
  - Register {MemAddr ← BASE_ADDR + 4*WordCount, MemWrData ← word}.
  - WordCount+1; go to PEND.
- Accept with invalid OpSel:
  - Word is dropped; no write; WordCount unchanged; Error ← 1.
  - State follows the MemReady/pending rules.
- PEND && MemReady && no new valid accept → IDLE. PEND && MemReady && new valid accept → stay in PEND with the new word (back-to-back).
- Full: InReady=0; the pending write still completes. No address wrap; further requests stall until Clear.
- Clear or Reset, including mid-PEND:
  - Pending write is dropped.
  - State IDLE; WordCount 0; Error 0.
- Clear and an accept in the same cycle: Clear wins and the request is not accepted.

## Timing
- Reset values:
  - MemWrEn 0, MemAddr 0, MemWrData 0.
  - WordCount 0, Full 0, Error 0.
  - InReady 1 (combinational from state).
- Latency: accept at edge N → MemWrEn high in cycle N+1.
- Throughput: one word per cycle while MemReady is held high.
- Outputs are registered, except InReady, which is combinational from state, Full and MemReady.
- MemAddr and MemWrData do not change while MemWrEn=1 && !MemReady.
- Error rises the cycle after the invalid accept.

## Test plan
- Reset, then ADDI (OpSel 3, Rs 1, Rt 2, Imm 0x0005), MemReady=1 → MemWrEn cycle N+1, MemAddr 0x0, MemWrData 0x20220005, WordCount 1.
- Back-to-back R-type (OpSel 0, Rs 1, Rt 2, Rd 3, Funct 0x20) then JAL (Target 0x10) → 0x00221820 @0x0, then 0x0C000010 @0x4 in consecutive cycles.
- LW (Rs 29, Rt 8, Imm 4) with MemReady low for 3 cycles → word 0x8FA80004 held stable and InReady=0 during the stall; then REGIMM (Rs 4, Rt 1, Imm 0xFFFF) → 0x0481FFFF @next address.
- LUI (Rs 7, Rt 9, Imm 0x1234) → 0x3C091234 with the rs field zeroed; OpSel 27 → no write, Error=1, WordCount unchanged.
- DEPTH=4: five requests → first four written at 0x0–0xC, Full=1, InReady=0, fifth request stalls; Clear → WordCount 0, next write @0x0.
- Reset asserted while in PEND with MemReady=0 → MemWrEn 0 next cycle, no write completes, all outputs at reset values.
